// File: rtl/vec_mem_stream.sv
// Vector unit-stride load/store streamer between the VRF ports and a
// ready/valid memory port. Loads keep up to MAXOUT reads in flight.
module vec_mem_stream #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned CW     = 8,
    parameter int unsigned MAXOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_vle32_v,
    input  logic          is_vse32_v,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] ITR,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_rdata,
    output logic [DW-1:0] vrf_wdata,
    output logic          stall_wr,
    input  logic [DW-1:0] vrf_rdata,
    input  logic          vrf_rdata_valid,
    output logic          stall_rd,
    output logic          busy,
    output logic          done
);

    localparam int unsigned OW = $clog2(MAXOUT) + 1;
    localparam logic [OW-1:0] MAXOUT_C = OW'(MAXOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_STORE,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] taken_q, taken_d;
    logic [OW-1:0] out_q, out_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          req_fire;
    logic          rsp_fire;
    logic          take;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        n_d           = n_q;
        issued_d      = issued_q;
        taken_d       = taken_q;
        out_d         = out_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        stall_wr      = 1'b1;
        stall_rd      = 1'b0;
        req_fire      = 1'b0;
        rsp_fire      = 1'b0;
        take          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (is_vle32_v ^ is_vse32_v)) begin
                    addr_d      = base_addr;
                    n_d         = ITR;
                    issued_d    = '0;
                    taken_d     = '0;
                    out_d       = '0;
                    hold_full_d = 1'b0;
                    if (ITR == '0)
                        state_d = S_FIN;
                    else if (is_vle32_v)
                        state_d = S_LOAD;
                    else
                        state_d = S_STORE;
                end
            end

            S_LOAD, S_DRAIN: begin
                // Responses with nothing outstanding are dropped, never counted.
                rsp_fire      = mem_rsp_valid && (out_q != '0);
                stall_wr      = !rsp_fire;
                mem_req_valid = (issued_q < n_q) && (out_q < MAXOUT_C);
                req_fire      = mem_req_valid && mem_req_ready;
                out_d         = out_q + OW'(req_fire) - OW'(rsp_fire);
                if (req_fire) begin
                    addr_d   = addr_q + AW'(4);
                    issued_d = issued_q + CW'(1);
                    if (issued_q + CW'(1) == n_q)
                        state_d = S_DRAIN;
                end
                if ((state_q == S_DRAIN) && rsp_fire && (out_d == '0))
                    state_d = S_FIN;
            end

            S_STORE: begin
                mem_req_valid = hold_full_q;
                mem_req_we    = 1'b1;
                req_fire      = hold_full_q && mem_req_ready;
                stall_rd      = hold_full_q && !mem_req_ready;
                // Refill is allowed in the same cycle the held element transfers.
                take          = vrf_rdata_valid && (taken_q < n_q) &&
                                (!hold_full_q || mem_req_ready);
                if (take) begin
                    hold_d  = vrf_rdata;
                    taken_d = taken_q + CW'(1);
                end
                hold_full_d = take || (hold_full_q && !mem_req_ready);
                if (req_fire) begin
                    addr_d   = addr_q + AW'(4);
                    issued_d = issued_q + CW'(1);
                    if (issued_q + CW'(1) == n_q)
                        state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            n_q         <= '0;
            issued_q    <= '0;
            taken_q     <= '0;
            out_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            issued_q    <= issued_d;
            taken_q     <= taken_d;
            out_q       <= out_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = hold_q;
    assign vrf_wdata     = mem_rsp_rdata;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);

endmodule

// File: tb/tb_vec_mem_stream.sv
// Scoreboard bench for vec_mem_stream: directed commands push expected
// requests/load data; a negedge monitor pops and compares.
module tb_vec_mem_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_vle32_v = 1'b0;
    logic        is_vse32_v = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  ITR = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic [31:0] vrf_wdata;
    logic        stall_wr;
    logic [31:0] vrf_rdata = '0;
    logic        vrf_rdata_valid = 1'b0;
    logic        stall_rd;
    logic        busy;
    logic        done;

    vec_mem_stream #(
        .AW(32),
        .DW(32),
        .CW(8),
        .MAXOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_vle32_v(is_vle32_v),
        .is_vse32_v(is_vse32_v),
        .base_addr(base_addr),
        .ITR(ITR),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .vrf_wdata(vrf_wdata),
        .stall_wr(stall_wr),
        .vrf_rdata(vrf_rdata),
        .vrf_rdata_valid(vrf_rdata_valid),
        .stall_rd(stall_rd),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rd_t;

    req_t        exp_req[$];
    logic [31:0] exp_ld[$];
    rd_t         rd_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned mem_lat = 2;
    int          issue_cnt = 0;
    int          ld_cnt = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    int          stall_ok = 0;
    int          any_valid = 0;
    int          w_done = 0;
    int          low_cnt = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    bit          hold_mode = 1'b0;
    bit          vrf_en = 1'b0;
    int          vrf_idx = 0;
    int          vrf_n = 0;
    logic [31:0] st_elem[4] = '{32'hCAFE_0001, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder and VRF read-side model, driven just after each edge.
    initial begin : driver
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rd_q[0].data;
                void'(rd_q.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = 32'h0;
            end
            mem_req_ready = !(hold_mode && w_done == 1 && low_cnt < 3);
            if (vrf_en) begin
                vrf_rdata_valid = 1'b1;
                vrf_rdata = (vrf_idx < vrf_n) ? st_elem[vrf_idx] : 32'hBAD0_0000;
            end else begin
                vrf_rdata_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        req_t r;
        rd_t  e;
        forever begin
            @(negedge clk);
            if (mem_rsp_valid)
                out_cnt--;
            if (mem_req_valid && mem_req_ready) begin
                issue_cnt++;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 32'(mem_req_valid), 32'd0);
                end else begin
                    r = exp_req.pop_front();
                    chk("req_addr", mem_req_addr, r.addr);
                    chk("req_we", 32'(mem_req_we), 32'(r.we));
                    if (r.we)
                        chk("req_wdata", mem_req_wdata, r.data);
                end
                if (!mem_req_we) begin
                    e.due  = cyc + mem_lat;
                    e.data = {mem_req_addr[15:0], 16'hD00D};
                    rd_q.push_back(e);
                    out_cnt++;
                    if (out_cnt > max_out)
                        max_out = out_cnt;
                end else begin
                    w_done++;
                end
            end
            if (!stall_wr) begin
                ld_cnt++;
                if (exp_ld.size() == 0)
                    chk("ld_unexpected", 32'(!stall_wr), 32'd0);
                else
                    chk("ld_data", vrf_wdata, exp_ld.pop_front());
            end
            if (done)
                done_cnt++;
            if (stall_rd) begin
                stall_cnt++;
                if (mem_req_addr == 32'h2004 && mem_req_wdata == st_elem[1])
                    stall_ok++;
            end
            if (mem_req_valid)
                any_valid++;
            if (mem_req_valid && !mem_req_ready)
                low_cnt++;
            if (vrf_rdata_valid && !stall_rd && vrf_idx < vrf_n)
                vrf_idx++;
        end
    end

    task automatic cmd(input bit ld, input bit st, input logic [31:0] base, input logic [7:0] n);
        @(posedge clk);
        #2;
        start = 1'b1;
        is_vle32_v = ld;
        is_vse32_v = st;
        base_addr = base;
        ITR = n;
        @(posedge clk);
        #2;
        start = 1'b0;
        is_vle32_v = 1'b0;
        is_vse32_v = 1'b0;
        base_addr = 32'hDEAD_BEEF;
        ITR = 8'hFF;
    endtask

    task automatic wait_done(input string tag, input int budget, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
        chk({tag, "_ld_left"}, 32'(exp_ld.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_we"}, 32'(mem_req_we), 32'd0);
        chk({tag, "_addr"}, mem_req_addr, 32'd0);
        chk({tag, "_wdata"}, mem_req_wdata, 32'd0);
        chk({tag, "_stall_wr"}, 32'(stall_wr), 32'd1);
        chk({tag, "_stall_rd"}, 32'(stall_rd), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [31:0] d);
        exp_req.push_back('{addr: a, we: 1'b0, data: 32'h0});
        exp_ld.push_back(d);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0;
        int l0;
        int a0;
        int i0;
        int k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Load, 3 elements, short fixed latency
        mem_lat = 2;
        push_rd(32'h0000_0100, 32'h0100_D00D);
        push_rd(32'h0000_0104, 32'h0104_D00D);
        push_rd(32'h0000_0108, 32'h0108_D00D);
        d0 = done_cnt;
        l0 = ld_cnt;
        cmd(1'b1, 1'b0, 32'h0000_0100, 8'd3);
        wait_done("A", 40, d0);
        chk("A_ld_cycles", 32'(ld_cnt - l0), 32'd3);

        // Load, 8 elements, long latency: in-flight limit must bite
        mem_lat = 10;
        out_cnt = 0;
        max_out = 0;
        for (int i = 0; i < 8; i++)
            push_rd(32'h300 + 32'(4 * i), ((32'h300 + 32'(4 * i)) << 16) | 32'hD00D);
        d0 = done_cnt;
        l0 = ld_cnt;
        cmd(1'b1, 1'b0, 32'h0000_0300, 8'd8);
        wait_done("B", 120, d0);
        chk("B_max_outstanding", 32'(max_out), 32'd4);
        chk("B_ld_cycles", 32'(ld_cnt - l0), 32'd8);

        // Store, 4 elements, memory stalls 3 cycles on element 1
        hold_mode = 1'b1;
        w_done = 0;
        low_cnt = 0;
        stall_cnt = 0;
        stall_ok = 0;
        vrf_idx = 0;
        vrf_n = 4;
        for (int i = 0; i < 4; i++)
            exp_req.push_back('{addr: 32'h2000 + 32'(4 * i), we: 1'b1, data: st_elem[i]});
        d0 = done_cnt;
        cmd(1'b0, 1'b1, 32'h0000_2000, 8'd4);
        vrf_en = 1'b1;
        wait_done("C", 60, d0);
        vrf_en = 1'b0;
        hold_mode = 1'b0;
        chk("C_stall_rd_cycles", 32'(stall_cnt), 32'd3);
        chk("C_stall_held_elem1", 32'(stall_ok), 32'd3);
        chk("C_writes", 32'(w_done), 32'd4);

        // Zero-length load
        a0 = any_valid;
        d0 = done_cnt;
        cmd(1'b1, 1'b0, 32'h0000_0700, 8'd0);
        wait_done("D", 2, d0);
        chk("D_no_req", 32'(any_valid - a0), 32'd0);

        // Both command bits set: ignored
        a0 = any_valid;
        d0 = done_cnt;
        cmd(1'b1, 1'b1, 32'h0000_0600, 8'd2);
        @(negedge clk);
        #1;
        chk("both_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("both_no_req", 32'(any_valid - a0), 32'd0);
        chk("both_no_done", 32'(done_cnt - d0), 32'd0);

        // Address wrap at top of memory
        mem_lat = 2;
        push_rd(32'hFFFF_FFFC, 32'hFFFC_D00D);
        push_rd(32'h0000_0000, 32'h0000_D00D);
        d0 = done_cnt;
        cmd(1'b1, 1'b0, 32'hFFFF_FFFC, 8'd2);
        wait_done("E", 40, d0);

        // Reset in DRAIN with two reads outstanding; late responses must vanish
        mem_lat = 10;
        exp_req.push_back('{addr: 32'h400, we: 1'b0, data: 32'h0});
        exp_req.push_back('{addr: 32'h404, we: 1'b0, data: 32'h0});
        i0 = issue_cnt;
        d0 = done_cnt;
        l0 = ld_cnt;
        cmd(1'b1, 1'b0, 32'h0000_0400, 8'd2);
        k = 0;
        while (issue_cnt - i0 < 2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("F_issued", 32'(issue_cnt - i0), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_reset("F_rst");
        k = 0;
        while ((rd_q.size() > 0 || mem_rsp_valid) && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("F_no_done", 32'(done_cnt - d0), 32'd0);
        chk("F_no_ld", 32'(ld_cnt - l0), 32'd0);
        chk("F_busy", 32'(busy), 32'd0);

        mem_lat = 2;
        push_rd(32'h0000_0500, 32'h0500_D00D);
        push_rd(32'h0000_0504, 32'h0504_D00D);
        d0 = done_cnt;
        l0 = ld_cnt;
        cmd(1'b1, 1'b0, 32'h0000_0500, 8'd2);
        wait_done("G", 40, d0);
        chk("G_ld_cycles", 32'(ld_cnt - l0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
